// File: rtl/wb_regfile_if.sv
// Write-back / register-read bus of the pipeline register file.
// The master drives the MEM/WB and ID-stage inputs. The slave returns the read data, the forwarded write-back value and the retire count.
interface wb_regfile_if #(
  parameter int W = 32
);
  logic         wb_mem_to_reg;
  logic         wb_reg_write;
  logic [W-1:0] wb_read_data;
  logic [W-1:0] wb_alu_res;
  logic [4:0]   wb_reg_dest;
  logic [4:0]   rs_addr;
  logic [4:0]   rt_addr;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic [W-1:0] wb_data;
  logic [31:0]  retire_count;

  modport master (
    output wb_mem_to_reg, wb_reg_write, wb_read_data, wb_alu_res, wb_reg_dest,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, retire_count
  );

  modport slave (
    input  wb_mem_to_reg, wb_reg_write, wb_read_data, wb_alu_res, wb_reg_dest,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Register file with a write-back mux, two combinational read ports and a write-through bypass.
// It also holds a free-running retire counter. Register 0 is hardwired to zero.
module wb_regfile #(
  parameter int W    = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [W-1:0] r_regs [NREG];
  logic [31:0]  r_retire_count;
  logic [W-1:0] w_wb_data;
  logic         w_wr_valid;
  logic [W-1:0] w_rs_data;
  logic [W-1:0] w_rt_data;

  assign w_wb_data  = bus.wb_mem_to_reg ? bus.wb_read_data : bus.wb_alu_res;
  assign w_wr_valid = bus.wb_reg_write && (bus.wb_reg_dest != 5'd0)
                      && ({1'b0, bus.wb_reg_dest} < NREG_L);

  // Bypass is gated by reset so that nothing leaks out while the array is cleared.
  function automatic logic [W-1:0] read_port(
    input logic         rst_n_i,
    input logic [4:0]   addr,
    input logic         we,
    input logic [4:0]   dest,
    input logic [W-1:0] wdata,
    input logic [W-1:0] stored
  );
    if (!rst_n_i || addr == 5'd0 || ({1'b0, addr} >= NREG_L))
      return '0;
    else if (we && dest == addr)
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    w_rs_data = read_port(rst, bus.rs_addr, bus.wb_reg_write, bus.wb_reg_dest,
                          w_wb_data, r_regs[bus.rs_addr]);
    w_rt_data = read_port(rst, bus.rt_addr, bus.wb_reg_write, bus.wb_reg_dest,
                          w_wb_data, r_regs[bus.rt_addr]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_retire_count <= '0;
    end else begin
      if (w_wr_valid) r_regs[bus.wb_reg_dest] <= w_wb_data;
      // Dest-0 writes still retire an instruction, so they are counted.
      if (bus.wb_reg_write) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign bus.rs_data      = w_rs_data;
  assign bus.rt_data      = w_rt_data;
  assign bus.wb_data      = w_wb_data;
  assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vectors, randomized traffic against a reference model,
// counter wrap, and asynchronous reset corner cases.
`timescale 1ns/10ps
module tb_wb_regfile;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wb_regfile_if #(.W(32)) bus ();

  wb_regfile #(.W(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and retire count.
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        m2r;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_wb;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_wb();
    return bus.wb_mem_to_reg ? bus.wb_read_data : bus.wb_alu_res;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (rst == 1'b0 || addr == 5'd0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_reg_dest == addr) return m_wb();
    return m_regs[addr];
  endfunction

  task automatic m_commit();
    if (rst && bus.wb_reg_write) begin
      m_cnt = m_cnt + 32'd1;
      if (bus.wb_reg_dest != 5'd0) m_regs[bus.wb_reg_dest] = m_wb();
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic drive(input logic m2r, input logic we, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] dest,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.wb_mem_to_reg = m2r;
    bus.wb_reg_write  = we;
    bus.wb_read_data  = rdata;
    bus.wb_alu_res    = alu;
    bus.wb_reg_dest   = dest;
    bus.rs_addr       = rs;
    bus.rt_addr       = rt;
  endtask

  // Commit the model and let the DUT take the edge, then settle.
  task automatic clock_edge();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_reset();

    vecs[0] = '{1'b0, 1'b1, 32'h0, 32'h12345678, 5'd5, 5'd5, 5'd0, 32'h12345678, 32'h12345678, 32'h0, 32'd1};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, 32'h0, 32'h12345678, 32'h12345678, 32'd1};
    vecs[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'd2};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h1, 5'd7, 5'd7, 5'd0, 32'h1, 32'h1, 32'h0, 32'd3};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 32'h1, 32'h1, 32'd3};
    vecs[6] = '{1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd4};
    vecs[7] = '{1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd5};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5A5A5, 32'd5};

    // Power-on reset, with a write pending that must not bypass.
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 32'h55AA55AA, 5'd3, 5'd3, 5'd3);
    #3;
    check("rst_rs_bypass_off", bus.rs_data, 32'h0);
    check("rst_wb_data_comb", bus.wb_data, 32'h55AA55AA);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.wb_reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = 5'(a);
      bus.rt_addr = 5'(31 - a);
      #1;
      check("reset_rs", bus.rs_data, 32'h0);
      check("reset_rt", bus.rt_data, 32'h0);
      @(negedge clk);
    end
    check("reset_count", bus.retire_count, 32'h0);

    // Directed vectors: combinational values before the edge, counter after it.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      drive(vecs[v].m2r, vecs[v].we, vecs[v].rdata, vecs[v].alu,
            vecs[v].dest, vecs[v].rs, vecs[v].rt);
      #1;
      check($sformatf("vec%0d_wb", v), bus.wb_data, vecs[v].e_wb);
      check($sformatf("vec%0d_rs", v), bus.rs_data, vecs[v].e_rs);
      check($sformatf("vec%0d_rt", v), bus.rt_data, vecs[v].e_rt);
      clock_edge();
      check($sformatf("vec%0d_cnt", v), bus.retire_count, vecs[v].e_cnt);
    end

    // Counter wrap via a backdoor preload.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    force dut.r_retire_count = 32'hFFFFFFFF;
    #1;
    release dut.r_retire_count;
    #1;
    check("wrap_preload", bus.retire_count, 32'hFFFFFFFF);
    m_cnt = 32'hFFFFFFFF;
    bus.wb_reg_write = 1'b1;
    clock_edge();
    check("wrap_zero", bus.retire_count, 32'h0);
    check("wrap_model", bus.retire_count, m_cnt);

    // Randomized traffic against the model, with results routed through the expected queue.
    for (int n = 0; n < 200; n++) begin
      logic [4:0] d;
      @(negedge clk);
      d = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      #1;
      exp_q.push_back(m_wb());
      exp_q.push_back(m_read(bus.rs_addr));
      exp_q.push_back(m_read(bus.rt_addr));
      check("rand_wb", bus.wb_data, exp_q.pop_front());
      check("rand_rs", bus.rs_data, exp_q.pop_front());
      check("rand_rt", bus.rt_data, exp_q.pop_front());
      clock_edge();
      check("rand_cnt", bus.retire_count, m_cnt);
    end

    // Fill regs 1..31, then pull reset between edges.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 32'h1000 + 32'(r), 5'(r), 5'(r), 5'd0);
      clock_edge();
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd1);
    #0.5;
    check("prefill_rs31", bus.rs_data, 32'h101F);
    rst = 1'b0;
    m_reset();
    #0.2;
    check("async_count", bus.retire_count, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = 5'(a);
      bus.rt_addr = 5'(a);
      #0.1;
      check("async_rs", bus.rs_data, 32'h0);
      check("async_rt", bus.rt_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.wb_reg_write = 1'b0;
    for (int a = 1; a < 32; a += 6) begin
      bus.rs_addr = 5'(a);
      #1;
      check("post_reset_rs", bus.rs_data, 32'h0);
      @(negedge clk);
    end

    // A write coincident with reset is lost.
    drive(1'b0, 1'b1, 32'h0, 32'h99, 5'd9, 5'd9, 5'd9);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.wb_reg_write = 1'b0;
    #1;
    check("coincident_lost", bus.rs_data, 32'h0);
    check("coincident_cnt", bus.retire_count, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
